// File: rtl/h264_transform_pkg.sv
// Shared types and helpers for the H.264 4x4 inverse core transform:
// FSM state encoding, zigzag scan lookup, rounding constants and saturation.
package h264_transform_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2
  } state_e;

  localparam int ROUND = 32;
  localparam int SHIFT = 6;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } rc_t;

  // Zigzag scan position -> matrix coordinate, matching the forward transform output order.
  function automatic rc_t zigzag(input logic [3:0] idx);
    rc_t rc;
    case (idx)
      4'd0:    rc = '{row: 2'd0, col: 2'd0};
      4'd1:    rc = '{row: 2'd0, col: 2'd1};
      4'd2:    rc = '{row: 2'd1, col: 2'd0};
      4'd3:    rc = '{row: 2'd2, col: 2'd0};
      4'd4:    rc = '{row: 2'd1, col: 2'd1};
      4'd5:    rc = '{row: 2'd0, col: 2'd2};
      4'd6:    rc = '{row: 2'd0, col: 2'd3};
      4'd7:    rc = '{row: 2'd1, col: 2'd2};
      4'd8:    rc = '{row: 2'd2, col: 2'd1};
      4'd9:    rc = '{row: 2'd3, col: 2'd0};
      4'd10:   rc = '{row: 2'd3, col: 2'd1};
      4'd11:   rc = '{row: 2'd2, col: 2'd2};
      4'd12:   rc = '{row: 2'd1, col: 2'd3};
      4'd13:   rc = '{row: 2'd2, col: 2'd3};
      4'd14:   rc = '{row: 2'd3, col: 2'd2};
      default: rc = '{row: 2'd3, col: 2'd3};
    endcase
    return rc;
  endfunction

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/h264invtransform_butterfly.sv
// Combinational 4-point H.264 inverse core butterfly, shared by the row pass
// and each of the four column lanes.
module h264invtransform_butterfly #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] d0_i,
  input  logic signed [W-1:0] d1_i,
  input  logic signed [W-1:0] d2_i,
  input  logic signed [W-1:0] d3_i,
  output logic signed [W-1:0] out0_o,
  output logic signed [W-1:0] out1_o,
  output logic signed [W-1:0] out2_o,
  output logic signed [W-1:0] out3_o
);

  logic signed [W-1:0] e0;
  logic signed [W-1:0] e1;
  logic signed [W-1:0] e2;
  logic signed [W-1:0] e3;

  assign e0 = d0_i + d2_i;
  assign e1 = d0_i - d2_i;
  assign e2 = (d1_i >>> 1) - d3_i;
  assign e3 = d1_i + (d3_i >>> 1);

  assign out0_o = e0 + e3;
  assign out1_o = e1 + e2;
  assign out2_o = e1 - e2;
  assign out3_o = e0 - e3;

endmodule

// File: rtl/h264invtransform.sv
// H.264 4x4 inverse integer transform: zigzag load, in-place row pass, then a
// four-lane column pass emitting one rounded, saturated residual row per cycle.
module h264invtransform
  import h264_transform_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  output logic                    READY,
  input  logic                    ENABLE,
  input  logic signed [IN_W-1:0]  COEFIN,
  output logic                    VALID,
  output logic [4*OUT_W-1:0]      XOUT,
  output logic                    LAST
);

  localparam int CW = IN_W + 2;
  localparam int VW = IN_W + 4;
  localparam logic signed [VW-1:0] RND = VW'(ROUND);

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [1:0]           row_q, row_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [4*OUT_W-1:0]   xout_q, xout_d;

  logic signed [CW-1:0] mat_q [4][4];
  logic signed [CW-1:0] row_f [4];
  logic signed [VW-1:0] col_h [4][4];
  logic signed [VW-1:0] rnd_v [4];
  logic [4*OUT_W-1:0]   col_row;
  rc_t                  zz;

  // Handshake: a coefficient moves on a rising edge where ENABLE && READY;
  // READY is high only in LOAD, and VALID rows carry no backpressure.
  assign READY = (state_q == ST_LOAD);
  assign VALID = valid_q;
  assign LAST  = last_q;
  assign XOUT  = xout_q;
  assign zz    = zigzag(idx_q);

  h264invtransform_butterfly #(.W(CW)) u_row_bfly (
    .d0_i   (mat_q[row_q][0]),
    .d1_i   (mat_q[row_q][1]),
    .d2_i   (mat_q[row_q][2]),
    .d3_i   (mat_q[row_q][3]),
    .out0_o (row_f[0]),
    .out1_o (row_f[1]),
    .out2_o (row_f[2]),
    .out3_o (row_f[3])
  );

  for (genvar j = 0; j < 4; j++) begin : g_col
    h264invtransform_butterfly #(.W(VW)) u_col_bfly (
      .d0_i   ({{(VW-CW){mat_q[0][j][CW-1]}}, mat_q[0][j]}),
      .d1_i   ({{(VW-CW){mat_q[1][j][CW-1]}}, mat_q[1][j]}),
      .d2_i   ({{(VW-CW){mat_q[2][j][CW-1]}}, mat_q[2][j]}),
      .d3_i   ({{(VW-CW){mat_q[3][j][CW-1]}}, mat_q[3][j]}),
      .out0_o (col_h[j][0]),
      .out1_o (col_h[j][1]),
      .out2_o (col_h[j][2]),
      .out3_o (col_h[j][3])
    );
  end

  // Output row row_q takes h[row_q] of every lane; shift floors toward -inf.
  always_comb begin
    col_row = '0;
    for (int j = 0; j < 4; j++) begin
      rnd_v[j] = (col_h[j][row_q] + RND) >>> SHIFT;
      col_row[j*OUT_W +: OUT_W] =
        OUT_W'(saturate({{(32-VW){rnd_v[j][VW-1]}}, rnd_v[j]}, OUT_W));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    xout_d  = xout_q;
    case (state_q)
      ST_LOAD: begin
        if (ENABLE) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = ST_ROW;
            row_d   = 2'd0;
          end
        end
      end
      ST_ROW: begin
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) state_d = ST_COL;
      end
      ST_COL: begin
        valid_d = 1'b1;
        last_d  = (row_q == 2'd3);
        xout_d  = col_row;
        row_d   = row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_d = ST_LOAD;
          idx_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = 4'd0;
        row_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_LOAD;
      idx_q   <= 4'd0;
      row_q   <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      xout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      xout_q  <= xout_d;
    end
  end

  // Matrix carries no reset: a reset block is always fully reloaded before use.
  always_ff @(posedge CLK) begin
    if (state_q == ST_LOAD && ENABLE) begin
      mat_q[zz.row][zz.col] <= {{(CW-IN_W){COEFIN[IN_W-1]}}, COEFIN};
    end else if (state_q == ST_ROW) begin
      for (int k = 0; k < 4; k++) mat_q[row_q][k] <= row_f[k];
    end
  end

endmodule
